// File: rtl/trace_packer.sv
// Trace packer: discards dropped trace items and queues kept ones in a FWFT FIFO on a valid/ready stream.
// Define TRACE_PACKER_SKIP_COUNT_EN to tag each item with the count of instructions dropped before it.
module trace_packer #(
  parameter int PC_WIDTH       = 64,
  parameter int INSTR_WIDTH    = 32,
  parameter int FIFO_DEPTH     = 16,
  parameter int SKIP_CNT_WIDTH = 16,
`ifdef TRACE_PACKER_SKIP_COUNT_EN
  localparam int OUT_W = PC_WIDTH + INSTR_WIDTH + SKIP_CNT_WIDTH
`else
  localparam int OUT_W = PC_WIDTH + INSTR_WIDTH
`endif
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          in_valid,
  input  logic [PC_WIDTH-1:0]           in_pc,
  input  logic [INSTR_WIDTH-1:0]        in_instr,
  input  logic                          drop_instr,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OUT_W-1:0]              out_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          clear_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || SKIP_CNT_WIDTH < 1)
  begin : g_bad_cfg
    $error("trace_packer: FIFO_DEPTH must be a power of two >= 2, SKIP_CNT_WIDTH >= 1");
  end

  logic [OUT_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             keep, pop, full, push, lost;
  logic [OUT_W-1:0] wr_data;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // A full FIFO still takes a kept item when the head leaves in the same cycle.
  always_comb begin
    keep = en & in_valid & ~drop_instr;
    pop  = valid_q & out_ready;
    full = (count_q == CW'(FIFO_DEPTH));
    push = keep & (~full | pop);
    lost = keep & full & ~pop;
  end

  always_comb begin
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    valid_d = (count_d != '0);
    // A lost item in the same cycle as a clear leaves the flag set.
    ovf_d = lost ? 1'b1 : (clear_overflow ? 1'b0 : ovf_q);
  end

`ifdef TRACE_PACKER_SKIP_COUNT_EN
  logic [SKIP_CNT_WIDTH-1:0] skip_cnt_q, skip_cnt_d;
  logic                      skip;

  // Lost items count as skipped; the count saturates rather than wrapping.
  always_comb begin
    skip       = en & in_valid & drop_instr;
    skip_cnt_d = skip_cnt_q;
    if (push)
      skip_cnt_d = '0;
    else if ((skip | lost) && !(&skip_cnt_q))
      skip_cnt_d = skip_cnt_q + SKIP_CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) skip_cnt_q <= '0;
    else     skip_cnt_q <= skip_cnt_d;
  end

  assign wr_data = {skip_cnt_q, in_pc, in_instr};
`else
  assign wr_data = {in_pc, in_instr};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wr_ptr_q] <= wr_data;
  end

  assign out_valid  = valid_q;
  assign out_data   = mem_q[rd_ptr_q];
  assign fifo_count = count_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_trace_packer.sv
// Randomized + directed bench for trace_packer: queue-based reference model and handshake scoreboard.
module tb_trace_packer;
  localparam int DEPTH = 16;
  localparam int SKMAX = 65535;
`ifdef TRACE_PACKER_SKIP_COUNT_EN
  localparam int OUT_W = 64 + 32 + 16;
`else
  localparam int OUT_W = 64 + 32;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0, in_valid = 1'b0, drop_instr = 1'b0;
  logic [63:0]      in_pc = '0;
  logic [31:0]      in_instr = '0;
  logic             out_valid, out_ready = 1'b0;
  logic [OUT_W-1:0] out_data;
  logic [4:0]       fifo_count;
  logic             overflow, clear_overflow = 1'b0;

  trace_packer dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_pc(in_pc),
    .in_instr(in_instr), .drop_instr(drop_instr), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .fifo_count(fifo_count),
    .overflow(overflow), .clear_overflow(clear_overflow)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  bit mon_on = 0;
  logic [OUT_W-1:0] exp_q [$];
  int mcount = 0, mskip = 0;
  bit movf = 0;

  function automatic logic [OUT_W-1:0] mk(input logic [63:0] pc, input logic [31:0] ins, input int skp);
`ifdef TRACE_PACKER_SKIP_COUNT_EN
    logic [15:0] s;
    s = skp[15:0];
    return {s, pc, ins};
`else
    return {pc, ins};
`endif
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h @%0t", name, got, exp, $time);
    end
  endtask

  // Monitor: state checks every cycle, data checked on each accepted handshake.
  always @(negedge clk) begin
    if (mon_on && !rst) begin
      chk("out_valid", 128'(out_valid), 128'(mcount != 0));
      chk("fifo_count", 128'(fifo_count), 128'(mcount));
      chk("overflow", 128'(overflow), 128'(movf));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_item", 128'(out_data), 128'(0));
        else chk("out_data", 128'(out_data), 128'(exp_q.pop_front()));
      end
    end
  end

  task automatic cyc(input bit e, input bit v, input bit d, input logic [63:0] pc,
                     input logic [31:0] ins, input bit rdy, input bit clr);
    bit kp, sk, pp, ps, ls;
    en = e; in_valid = v; drop_instr = d; in_pc = pc; in_instr = ins;
    out_ready = rdy; clear_overflow = clr;
    pp = (mcount != 0) && rdy;
    kp = e && v && !d;
    sk = e && v && d;
    ps = kp && (mcount < DEPTH || pp);
    ls = kp && !ps;
    @(posedge clk); #1;
    if (ps) begin
      exp_q.push_back(mk(pc, ins, mskip));
      mskip = 0;
    end else if ((sk || ls) && mskip != SKMAX) mskip++;
    if (ls) movf = 1; else if (clr) movf = 0;
    mcount = mcount + int'(ps) - int'(pp);
  endtask

  task automatic do_reset();
    rst = 1; en = 1; in_valid = 1; drop_instr = 0;
    in_pc = {$urandom, $urandom}; in_instr = $urandom; out_ready = 1; clear_overflow = 0;
    @(posedge clk); #1;
    rst = 0;
    exp_q.delete(); mcount = 0; mskip = 0; movf = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, '0, '0, 1, 0);
  endtask

  initial begin
    do_reset();
    mon_on = 1;
    // single jal
    cyc(1, 1, 0, 64'h8000_0000, 32'h0000_006F, 1, 0);
    idle(3);
    // three drops then beq
    for (int i = 0; i < 3; i++) cyc(1, 1, 1, 64'h8000_0004 + 64'(4*i), 32'h0010_0093, 1, 0);
    cyc(1, 1, 0, 64'h8000_0010, 32'h0000_0063, 1, 0);
    idle(3);
    // fill, full-with-pop, lost item, clear vs lost, drain
    do_reset();
    for (int i = 0; i < DEPTH; i++) cyc(1, 1, 0, 64'h1000 + 64'(4*i), 32'h0000_006F + 32'(i << 12), 0, 0);
    cyc(1, 1, 0, 64'h2000, 32'h0000_0063, 1, 0);
    cyc(1, 1, 0, 64'h2004, 32'h0000_0067, 0, 0);
    cyc(1, 1, 0, 64'h2008, 32'h0000_0067, 0, 1);
    cyc(1, 0, 0, '0, '0, 0, 1);
    idle(4);
    cyc(1, 1, 0, 64'h3000, 32'h1050_0073, 1, 0);
    idle(DEPTH + 4);
    // reset flushes buffered items and the skip count; en=0 ignores kept items
    for (int i = 0; i < 5; i++) cyc(1, 1, 0, 64'h4000 + 64'(4*i), 32'h0000_006F, 0, 0);
    cyc(1, 1, 1, 64'h4100, 32'h0010_0093, 0, 0);
    cyc(1, 1, 1, 64'h4104, 32'h0010_0093, 0, 0);
    do_reset();
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 64'h5000 + 64'(4*i), 32'h0000_006F, 1, 0);
    cyc(1, 1, 0, 64'h5100, 32'h0000_0063, 1, 0);
    idle(3);
`ifdef TRACE_PACKER_SKIP_COUNT_EN
    // saturation of the skip field
    for (int i = 0; i < SKMAX + 5; i++) cyc(1, 1, 1, 64'h6000, 32'h0010_0093, 1, 0);
    cyc(1, 1, 0, 64'h6004, 32'h0000_006F, 1, 0);
    idle(3);
`endif
    // random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      else cyc($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
               {$urandom, $urandom}, $urandom, $urandom_range(0, 9) < 5, $urandom_range(0, 19) == 0);
    end
    idle(DEPTH + 4);
    chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
